// File: rtl/cache_control_nway_if.sv
// Bus bundle between the cache controller, the cache datapath and the memory port.
// The master modport is the controller side; the slave modport is the datapath/memory side.
interface cache_control_nway_if #(
    parameter int WAY_W  = 1,
    parameter int BEAT_W = 2
) ();
    logic              cache_read;
    logic              cache_write;
    logic              cache_hit;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  victim_way;
    logic              victim_dirty;
    logic              pmem_resp;

    logic              cache_resp;
    logic [WAY_W-1:0]  way_sel;
    logic              data_we;
    logic              tag_load;
    logic              dirty_load;
    logic              dirty_in;
    logic              lru_load;
    logic              pmem_read;
    logic              pmem_write;
    logic              addr_sel;
    logic [BEAT_W-1:0] beat_idx;

    modport master (
        input  cache_read, cache_write, cache_hit, hit_way, victim_way, victim_dirty, pmem_resp,
        output cache_resp, way_sel, data_we, tag_load, dirty_load, dirty_in, lru_load,
               pmem_read, pmem_write, addr_sel, beat_idx
    );

    modport slave (
        output cache_read, cache_write, cache_hit, hit_way, victim_way, victim_dirty, pmem_resp,
        input  cache_resp, way_sel, data_we, tag_load, dirty_load, dirty_in, lru_load,
               pmem_read, pmem_write, addr_sel, beat_idx
    );
endinterface

// File: rtl/cache_control_nway.sv
// N-way set-associative cache controller: zero-latency hit path, dirty-victim
// writeback and line fill bursts, plus saturating hit/miss/writeback counters.
//
// state     | meaning
// CHECK     | idle / tag compare; hits answered in the same cycle
// WRITEBACK | bursting the dirty victim line out to memory
// FILL      | bursting the requested line from memory into the victim way
module cache_control_nway #(
    parameter int WAYS  = 2,
    parameter int BEATS = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    cache_control_nway_if.master bus,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
);

    localparam int WAY_W  = ($clog2(WAYS) > 1) ? $clog2(WAYS) : 1;
    localparam int BEAT_W = ($clog2(BEATS) > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        CHECK,
        WRITEBACK,
        FILL
    } state_t;

    state_t            state;
    logic [WAY_W-1:0]  victim_q;
    logic [BEAT_W-1:0] beat_q;

    logic              req;
    logic              last_beat;
    logic              resp;
    logic [WAY_W-1:0]  way_sel;
    logic              data_we;
    logic              tag_load;
    logic              dirty_load;
    logic              dirty_in;
    logic              lru_load;
    logic              pmem_read;
    logic              pmem_write;
    logic              addr_sel;
    logic [BEAT_W-1:0] beat_idx;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    assign req       = bus.cache_read | bus.cache_write;
    assign last_beat = bus.pmem_resp && (beat_q == BEAT_LAST);

    // Outputs are Mealy so a hit completes in the cycle it is presented.
    always_comb begin
        resp       = 1'b0;
        way_sel    = '0;
        data_we    = 1'b0;
        tag_load   = 1'b0;
        dirty_load = 1'b0;
        dirty_in   = 1'b0;
        lru_load   = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        addr_sel   = 1'b0;
        beat_idx   = '0;
        if (!rst) begin
            case (state)
                CHECK: begin
                    if (req && bus.cache_hit) begin
                        resp     = 1'b1;
                        lru_load = 1'b1;
                        way_sel  = bus.hit_way;
                        if (bus.cache_write) begin
                            dirty_load = 1'b1;
                            dirty_in   = 1'b1;
                        end
                    end
                end
                WRITEBACK: begin
                    way_sel    = victim_q;
                    beat_idx   = beat_q;
                    addr_sel   = 1'b1;
                    pmem_write = !last_beat;
                    dirty_load = last_beat;
                end
                FILL: begin
                    way_sel    = victim_q;
                    beat_idx   = beat_q;
                    pmem_read  = !last_beat;
                    data_we    = bus.pmem_resp;
                    tag_load   = last_beat;
                    dirty_load = last_beat;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CHECK;
            victim_q   <= '0;
            beat_q     <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (resp)
                hit_count <= sat_inc(hit_count);
            case (state)
                CHECK: begin
                    if (req && !bus.cache_hit) begin
                        victim_q   <= bus.victim_way;
                        beat_q     <= '0;
                        miss_count <= sat_inc(miss_count);
                        if (bus.victim_dirty) begin
                            state    <= WRITEBACK;
                            wb_count <= sat_inc(wb_count);
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.pmem_resp) begin
                        if (last_beat) begin
                            beat_q <= '0;
                            state  <= FILL;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                FILL: begin
                    // A withdrawn request still runs the burst to completion.
                    if (bus.pmem_resp) begin
                        if (last_beat) begin
                            beat_q <= '0;
                            state  <= CHECK;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                default: state <= CHECK;
            endcase
        end
    end

    assign bus.cache_resp = resp;
    assign bus.way_sel    = way_sel;
    assign bus.data_we    = data_we;
    assign bus.tag_load   = tag_load;
    assign bus.dirty_load = dirty_load;
    assign bus.dirty_in   = dirty_in;
    assign bus.lru_load   = lru_load;
    assign bus.pmem_read  = pmem_read;
    assign bus.pmem_write = pmem_write;
    assign bus.addr_sel   = addr_sel;
    assign bus.beat_idx   = beat_idx;

endmodule

// File: tb/tb_cache_control_nway.sv
// Directed bench for cache_control_nway with WAYS=4, BEATS=4, CNT_W=4.
module tb_cache_control_nway;

    logic       clk;
    logic       rst;
    logic [3:0] hit_count;
    logic [3:0] miss_count;
    logic [3:0] wb_count;
    int         checks;
    int         errors;

    cache_control_nway_if #(.WAY_W(2), .BEAT_W(2)) bus ();

    cache_control_nway #(.WAYS(4), .BEATS(4), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .wb_count   (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.cache_read   = 1'b0;
        bus.cache_write  = 1'b0;
        bus.cache_hit    = 1'b0;
        bus.hit_way      = '0;
        bus.victim_way   = '0;
        bus.victim_dirty = 1'b0;
        bus.pmem_resp    = 1'b0;
    endtask

    task automatic chk_fill_beats(input string tag, input logic [1:0] way, input int gap);
        for (int b = 0; b < 4; b++) begin
            if (gap != 0) begin
                bus.pmem_resp = 1'b0;
                #1;
                chk({tag, "_gap_we"}, bus.data_we, 0);
                chk({tag, "_gap_rd"}, bus.pmem_read, 1);
                chk({tag, "_gap_beat"}, bus.beat_idx, b);
                tick;
            end
            bus.pmem_resp = 1'b1;
            #1;
            chk({tag, "_we"}, bus.data_we, 1);
            chk({tag, "_beat"}, bus.beat_idx, b);
            chk({tag, "_way"}, bus.way_sel, way);
            chk({tag, "_addr"}, bus.addr_sel, 0);
            chk({tag, "_wr"}, bus.pmem_write, 0);
            chk({tag, "_rd"}, bus.pmem_read, (b == 3) ? 0 : 1);
            chk({tag, "_tag"}, bus.tag_load, (b == 3) ? 1 : 0);
            chk({tag, "_dirty"}, bus.dirty_load, (b == 3) ? 1 : 0);
            tick;
        end
        bus.pmem_resp = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        rst = 1'b1;
        tick;
        tick;

        // Outputs stay quiet under reset even with a hitting request present.
        bus.cache_read = 1'b1;
        bus.cache_hit  = 1'b1;
        bus.hit_way    = 2'd2;
        #1;
        chk("rst_resp", bus.cache_resp, 0);
        chk("rst_lru", bus.lru_load, 0);
        chk("rst_way", bus.way_sel, 0);
        idle_inputs();
        rst = 1'b0;
        #1;
        chk("idle_resp", bus.cache_resp, 0);
        chk("idle_way", bus.way_sel, 0);
        chk("idle_rd", bus.pmem_read, 0);
        chk("idle_wr", bus.pmem_write, 0);
        chk("idle_hits", hit_count, 0);
        chk("idle_miss", miss_count, 0);
        chk("idle_wb", wb_count, 0);

        // Read hit on way 2
        bus.cache_read = 1'b1;
        bus.cache_hit  = 1'b1;
        bus.hit_way    = 2'd2;
        #1;
        chk("rhit_resp", bus.cache_resp, 1);
        chk("rhit_lru", bus.lru_load, 1);
        chk("rhit_way", bus.way_sel, 2);
        chk("rhit_dirty", bus.dirty_load, 0);
        tick;
        chk("rhit_count", hit_count, 1);

        // Write hit on way 3
        bus.cache_read  = 1'b0;
        bus.cache_write = 1'b1;
        bus.hit_way     = 2'd3;
        #1;
        chk("whit_resp", bus.cache_resp, 1);
        chk("whit_dload", bus.dirty_load, 1);
        chk("whit_din", bus.dirty_in, 1);
        chk("whit_way", bus.way_sel, 3);
        tick;

        // Read and write together behave as a write
        bus.cache_read = 1'b1;
        bus.hit_way    = 2'd1;
        #1;
        chk("both_dload", bus.dirty_load, 1);
        chk("both_way", bus.way_sel, 1);
        tick;
        chk("both_count", hit_count, 3);

        // Clean miss, victim 1; victim_way wiggling during FILL is ignored
        idle_inputs();
        bus.cache_read   = 1'b1;
        bus.victim_way   = 2'd1;
        #1;
        chk("cmiss_resp", bus.cache_resp, 0);
        tick;
        bus.victim_way = 2'd2;
        chk("cmiss_count", miss_count, 1);
        chk("cmiss_wbcnt", wb_count, 0);
        chk_fill_beats("cfill", 2'd1, 1);
        bus.cache_hit = 1'b1;
        bus.hit_way   = 2'd1;
        #1;
        chk("cmiss_recheck", bus.cache_resp, 1);
        chk("cmiss_rc_way", bus.way_sel, 1);
        tick;
        chk("cmiss_hits", hit_count, 4);

        // Dirty miss, victim 0; victim_way moves to 3 mid-writeback
        idle_inputs();
        bus.cache_write  = 1'b1;
        bus.victim_dirty = 1'b1;
        tick;
        bus.victim_way   = 2'd3;
        bus.victim_dirty = 1'b0;
        chk("dmiss_wbcnt", wb_count, 1);
        chk("dmiss_count", miss_count, 2);
        for (int b = 0; b < 4; b++) begin
            bus.pmem_resp = 1'b1;
            #1;
            chk("wb_beat", bus.beat_idx, b);
            chk("wb_way", bus.way_sel, 0);
            chk("wb_addr", bus.addr_sel, 1);
            chk("wb_rd", bus.pmem_read, 0);
            chk("wb_wr", bus.pmem_write, (b == 3) ? 0 : 1);
            chk("wb_dload", bus.dirty_load, (b == 3) ? 1 : 0);
            chk("wb_din", bus.dirty_in, 0);
            chk("wb_we", bus.data_we, 0);
            tick;
        end
        chk_fill_beats("dfill", 2'd0, 0);
        bus.cache_hit = 1'b1;
        bus.hit_way   = 2'd0;
        #1;
        chk("dmiss_recheck", bus.cache_resp, 1);
        chk("dmiss_rc_din", bus.dirty_in, 1);
        tick;
        chk("dmiss_hits", hit_count, 5);

        // Request withdrawn mid-fill: burst completes, then idle; stray resp ignored
        idle_inputs();
        bus.cache_read = 1'b1;
        tick;
        bus.cache_read = 1'b0;
        chk_fill_beats("wfill", 2'd0, 1);
        bus.pmem_resp = 1'b1;
        #1;
        chk("stray_we", bus.data_we, 0);
        chk("stray_rd", bus.pmem_read, 0);
        chk("stray_beat", bus.beat_idx, 0);
        tick;
        bus.pmem_resp = 1'b0;
        chk("wd_miss", miss_count, 3);
        chk("wd_hits", hit_count, 5);
        chk("wd_wb", wb_count, 1);

        // Reset after two fill beats
        bus.cache_read = 1'b1;
        bus.victim_way = 2'd2;
        tick;
        bus.pmem_resp = 1'b1;
        tick;
        tick;
        bus.pmem_resp = 1'b0;
        rst = 1'b1;
        #1;
        chk("mrst_rd_during", bus.pmem_read, 0);
        tick;
        rst = 1'b0;
        bus.cache_read = 1'b0;
        #1;
        chk("mrst_rd", bus.pmem_read, 0);
        chk("mrst_beat", bus.beat_idx, 0);
        chk("mrst_hits", hit_count, 0);
        chk("mrst_miss", miss_count, 0);
        chk("mrst_wb", wb_count, 0);
        bus.cache_read = 1'b1;
        bus.cache_hit  = 1'b1;
        bus.hit_way    = 2'd2;
        #1;
        chk("mrst_in_check", bus.cache_resp, 1);

        // 16 consecutive hits saturate the 4-bit counter
        for (int i = 0; i < 16; i++) tick;
        chk("sat_16", hit_count, 15);
        tick;
        chk("sat_17", hit_count, 15);

        idle_inputs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_control_nway.md
CACHE_CONTROL_NWAY -- requirements
Module: cache_control_nway

Interface
REQ-001 Parameter WAYS, default 2, associativity; power of two, >= 2.
REQ-002 Parameter BEATS, default 4, physical-memory burst length in beats per line; power of two, >= 1.
REQ-003 Parameter CNT_W, default 32, width of each performance counter.
REQ-004 Derived widths SHALL be WAY_W = max(1, clog2(WAYS)) and BEAT_W = max(1, clog2(BEATS)).
REQ-005 Clocking and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 cache_read  in  1  CPU read request; held until cache_resp.
REQ-009 cache_write  in  1  CPU write request; held until cache_resp.
REQ-010 cache_hit  in  1  tag match in any way, from the datapath.
REQ-011 hit_way  in  WAY_W  matching way; valid only when cache_hit=1.
REQ-012 victim_way  in  WAY_W  LRU replacement candidate.
REQ-013 victim_dirty  in  1  dirty bit of victim_way.
REQ-014 pmem_resp  in  1  one pulse per completed memory beat.
REQ-015 cache_resp  out  1  CPU request complete.
REQ-016 way_sel  out  WAY_W  way addressed by the datapath this cycle.
REQ-017 data_we  out  1  write one fill beat into way_sel at beat_idx.
REQ-018 tag_load  out  1  load tag and valid bit for way_sel.
REQ-019 dirty_load  out  1  write dirty_in into the dirty bit of way_sel.
REQ-020 dirty_in  out  1  dirty value to write.
REQ-021 lru_load  out  1  update LRU with way_sel as most recently used.
REQ-022 pmem_read  out  1  memory burst read active.
REQ-023 pmem_write  out  1  memory burst write active.
REQ-024 addr_sel  out  1  0 = CPU line address, 1 = victim tag address.
REQ-025 beat_idx  out  BEAT_W  current beat within the burst.
REQ-026 hit_count, miss_count, wb_count  out  CNT_W each  performance counters.

Function
REQ-027 The state machine SHALL have three states: CHECK, WRITEBACK and FILL.
REQ-028 In CHECK, when a request is present and cache_hit=1: cache_resp=1, lru_load=1 and way_sel=hit_way, all combinationally in the same cycle (0-cycle hit latency).
REQ-029 A write hit SHALL additionally assert dirty_load=1 with dirty_in=1.
REQ-030 If cache_read and cache_write are both asserted, the request SHALL be treated as a write.
REQ-031 On a CHECK miss, victim_way SHALL be latched into a victim register and beat counter reset to 0.
REQ-032 On a CHECK miss, next state SHALL be WRITEBACK if victim_dirty=1, otherwise FILL.
REQ-033 In WRITEBACK and FILL, way_sel SHALL equal the latched victim register; later changes of victim_way are ignored.
REQ-034 WRITEBACK SHALL drive pmem_write=1 and addr_sel=1.
REQ-035 In WRITEBACK, each pmem_resp increments beat_idx; on the resp with beat_idx=BEATS-1: dirty_load=1, dirty_in=0, counter wraps to 0, next state FILL.
REQ-036 FILL SHALL drive pmem_read=1 and addr_sel=0.
REQ-037 In FILL, each pmem_resp pulses data_we=1 at the current beat_idx, then increments beat_idx.
REQ-038 On the last FILL beat: tag_load=1, dirty_load=1, dirty_in=0, counter wraps to 0, next state CHECK.
REQ-039 pmem_read and pmem_write SHALL be deasserted in the cycle of the last pmem_resp and never asserted together.
REQ-040 After FILL, the request SHALL be re-evaluated in CHECK, hits and receives cache_resp; miss latency = 1 + BEATS beats (clean) or 1 + 2*BEATS beats (dirty), plus the re-check cycle.
REQ-041 A request withdrawn mid-miss SHALL NOT abort the burst; it completes, then the block returns to CHECK idle.
REQ-042 pmem_resp in CHECK SHALL be ignored.
REQ-043 Counter updates:
- hit_count +1 per cycle with cache_resp=1.
- miss_count +1 per CHECK miss entry.
- wb_count +1 per WRITEBACK entry.
- Each counter saturates at all-ones.
REQ-044 When no request is present in CHECK, all outputs SHALL be 0 except the counters; way_sel=0.

Reset
REQ-045 rst SHALL force state CHECK, beat counter 0, victim register 0 and all counters 0 on the next edge, including mid-burst.
REQ-046 During and after reset, all control outputs SHALL be 0.

Verification
REQ-047 WAYS=4, BEATS=4: read with cache_hit=1, hit_way=2 -> same-cycle cache_resp=1, lru_load=1, way_sel=2; hit_count=1.
REQ-048 Write hit, hit_way=3 -> cache_resp=1, dirty_load=1, dirty_in=1, way_sel=3.
REQ-049 Clean miss, victim_way=1 -> FILL; 4 pmem_resp give data_we at beat_idx 0..3; tag_load on the 4th; next cycle hit -> cache_resp; miss_count=1.
REQ-050 Dirty miss, victim_way=0; victim_way changes to 3 during WRITEBACK -> 4 write beats then 4 read beats, way_sel=0 throughout; wb_count=1.
REQ-051 rst asserted after 2 FILL beats -> next cycle state CHECK, pmem_read=0, beat_idx=0, all counters 0.
REQ-052 CNT_W=4: 16 hits -> hit_count stays at 15.
